// File: rtl/control_sequencer.sv
// Lane walker: on an accepted start, enables lanes 0..target one at a time,
// holding each for DWELL cycles, then pulses done. All outputs are registered.
module control_sequencer #(
    parameter int LANES = 8,
    parameter int IDXW  = 3,
    parameter int DWELL = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LANES-1:0] control,
    output logic [LANES-1:0] lane_en,
    output logic [IDXW-1:0]  lane_idx,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_FIN   = 2'd2;
    localparam logic [3:0] DW_LAST = 4'(DWELL - 1);

    logic [1:0]       state_q, state_d;
    logic [IDXW-1:0]  tgt_q, tgt_d;
    logic [IDXW-1:0]  lane_q, lane_d;
    logic [3:0]       dwell_q, dwell_d;
    logic [LANES-1:0] lane_en_q, lane_en_d;
    logic [IDXW-1:0]  lane_idx_q, lane_idx_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic [IDXW:0]    ones;
    logic [IDXW-1:0]  enc;
    logic             onehot;

    // Popcount and position of the set bit; enc is only meaningful when one-hot.
    always_comb begin
        ones = '0;
        enc  = '0;
        for (int i = 0; i < LANES; i++) begin
            if (control[i]) begin
                ones = ones + 1'b1;
                enc  = IDXW'(i);
            end
        end
    end

    assign onehot = (state_q == S_IDLE) && (ones == (IDXW+1)'(1));

    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        lane_d  = lane_q;
        dwell_d = dwell_q;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (onehot) begin
                        tgt_d   = enc;
                        lane_d  = '0;
                        dwell_d = '0;
                        state_d = S_RUN;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (dwell_q == DW_LAST) begin
                    dwell_d = '0;
                    if (lane_q == tgt_q) state_d = S_FIN;
                    else                 lane_d  = lane_q + 1'b1;
                end else begin
                    dwell_d = dwell_q + 1'b1;
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they line up with it after the edge.
    always_comb begin
        busy_d     = (state_d == S_RUN);
        done_d     = (state_d == S_FIN);
        lane_idx_d = busy_d ? lane_d : '0;
        lane_en_d  = busy_d ? (LANES'(1) << lane_d) : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            tgt_q      <= '0;
            lane_q     <= '0;
            dwell_q    <= '0;
            lane_en_q  <= '0;
            lane_idx_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            tgt_q      <= tgt_d;
            lane_q     <= lane_d;
            dwell_q    <= dwell_d;
            lane_en_q  <= lane_en_d;
            lane_idx_q <= lane_idx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign lane_en  = lane_en_q;
    assign lane_idx = lane_idx_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: two instances (DWELL=1 and DWELL=3) share stimulus
// and are checked each cycle against an elapsed-time model, plus pinned literals.
module tb_control_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] control;

    logic [7:0] en   [2];
    logic [2:0] idx  [2];
    logic       busy [2];
    logic       done [2];
    logic       err  [2];

    int DW [2] = '{1, 3};

    // model: mode 0 idle, 1 run, 2 done cycle; me = cycles elapsed in the run
    int mmode [2];
    int mtgt  [2];
    int me    [2];
    bit merr  [2];

    int errors = 0;
    int checks = 0;
    int bcnt [2] = '{0, 0};
    int dcnt [2] = '{0, 0};
    int ecnt [2] = '{0, 0};
    logic [7:0] seq0 [$];

    always #5 clk = ~clk;

    control_sequencer #(.LANES(8), .IDXW(3), .DWELL(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .start(start), .control(control),
        .lane_en(en[0]), .lane_idx(idx[0]), .busy(busy[0]), .done(done[0]), .err(err[0]));

    control_sequencer #(.LANES(8), .IDXW(3), .DWELL(3)) u_d3 (
        .clk(clk), .rst_n(rst_n), .start(start), .control(control),
        .lane_en(en[1]), .lane_idx(idx[1]), .busy(busy[1]), .done(done[1]), .err(err[1]));

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            merr[i] = 1'b0;
            if (!rst_n) begin
                mmode[i] = 0;
            end else begin
                case (mmode[i])
                    0: if (start) begin
                        if ($countones(control) == 1) begin
                            for (int b = 0; b < 8; b++) if (control[b]) mtgt[i] = b;
                            me[i]    = 0;
                            mmode[i] = 1;
                        end else begin
                            merr[i] = 1'b1;
                        end
                    end
                    1: begin
                        me[i]++;
                        if (me[i] == (mtgt[i] + 1) * DW[i]) mmode[i] = 2;
                    end
                    default: mmode[i] = 0;
                endcase
            end
        end
    endtask

    // One clock: advance the model, take the edge, compare at the falling edge.
    task automatic cyc();
        int   e_idx;
        logic [7:0] e_en;
        model_edge();
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            e_idx = (mmode[i] == 1) ? me[i] / DW[i] : 0;
            e_en  = (mmode[i] == 1) ? (8'd1 << e_idx) : 8'd0;
            chk($sformatf("busy[d%0d]", DW[i]),     int'(busy[i]), int'(mmode[i] == 1));
            chk($sformatf("lane_idx[d%0d]", DW[i]), int'(idx[i]),  e_idx);
            chk($sformatf("lane_en[d%0d]", DW[i]),  int'(en[i]),   int'(e_en));
            chk($sformatf("done[d%0d]", DW[i]),     int'(done[i]), int'(mmode[i] == 2));
            chk($sformatf("err[d%0d]", DW[i]),      int'(err[i]),  int'(merr[i]));
            if (busy[i]) bcnt[i]++;
            if (done[i]) dcnt[i]++;
            if (err[i])  ecnt[i]++;
        end
        if (busy[0]) seq0.push_back(en[0]);
    endtask

    task automatic pulse_start(input logic [7:0] c);
        control = c;
        start   = 1'b1;
        cyc();
        start   = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        int n = 0;
        while ((mmode[0] != 0 || mmode[1] != 0) && n < bound) begin
            cyc();
            n++;
        end
        if (n >= bound) chk("wait_idle_timeout", n, -1);
        cyc();
    endtask

    initial begin
        int b0, b1, d0, d1, e0, e1, n;
        logic [7:0] want [4];
        rst_n = 1'b0; start = 1'b1; control = 8'h08;
        for (int i = 0; i < 2; i++) begin mmode[i] = 0; mtgt[i] = 0; me[i] = 0; merr[i] = 0; end
        repeat (3) cyc();
        start = 1'b0; rst_n = 1'b1;
        repeat (2) cyc();
        chk("reset_lane_en", int'(en[1]), 0);
        chk("reset_flags", int'({busy[0], done[0], err[0]}), 0);

        // basic walk, DWELL=1 and 3, target 3
        seq0.delete();
        d0 = dcnt[0];
        pulse_start(8'h08);
        wait_idle(40);
        want = '{8'h01, 8'h02, 8'h04, 8'h08};
        chk("walk_len", seq0.size(), 4);
        for (int i = 0; i < 4 && i < seq0.size(); i++) chk($sformatf("walk_step%0d", i), int'(seq0[i]), int'(want[i]));
        chk("walk_done_count", dcnt[0] - d0, 1);

        // extremes
        b0 = bcnt[0]; b1 = bcnt[1]; d1 = dcnt[1];
        pulse_start(8'h80);
        wait_idle(60);
        chk("t7_busy_d1", bcnt[0] - b0, 8);
        chk("t7_busy_d3", bcnt[1] - b1, 24);
        chk("t7_done_d3", dcnt[1] - d1, 1);
        b1 = bcnt[1];
        pulse_start(8'h01);
        wait_idle(20);
        chk("t0_busy_d3", bcnt[1] - b1, 3);

        // illegal control
        e0 = ecnt[0]; b0 = bcnt[0];
        pulse_start(8'h00); cyc();
        chk("err_zero", ecnt[0] - e0, 1);
        pulse_start(8'h0C); cyc();
        chk("err_multi", ecnt[0] - e0, 2);
        chk("err_no_busy", bcnt[0] - b0, 0);

        // start and control ignored while running
        d1 = dcnt[1]; e1 = ecnt[1]; b1 = bcnt[1];
        pulse_start(8'h04);
        cyc();
        control = 8'h80; start = 1'b1; cyc(); start = 1'b0; cyc();
        start = 1'b1; cyc(); start = 1'b0; control = 8'h00;
        wait_idle(40);
        chk("ign_busy_d3", bcnt[1] - b1, 9);
        chk("ign_done", dcnt[1] - d1, 1);
        chk("ign_err", ecnt[1] - e1, 0);

        // reset mid-run at lane 3
        d1 = dcnt[1];
        pulse_start(8'h40);
        n = 0;
        while (idx[1] != 3'd3 && n < 30) begin cyc(); n++; end
        chk("midrun_reached_lane3", int'(idx[1]), 3);
        rst_n = 1'b0; cyc(); rst_n = 1'b1;
        chk("midrun_rst_lane_en", int'(en[1]), 0);
        repeat (3) cyc();
        chk("midrun_no_done", dcnt[1] - d1, 0);
        seq0.delete();
        pulse_start(8'h02);
        wait_idle(20);
        chk("after_rst_first", (seq0.size() > 0) ? int'(seq0[0]) : -1, 1);

        // randomized traffic
        for (int k = 0; k < 600; k++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            start = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 4) == 0) control = 8'($urandom());
            else                           control = 8'd1 << $urandom_range(0, 7);
            cyc();
        end
        rst_n = 1'b1; start = 1'b0;
        wait_idle(60);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
